// File: rtl/symm_orth_iter_if.sv
// Handshake and matrix bus of the symmetric-orthogonalisation engine.
// The W-register bank side drives the master modport; the engine takes the slave modport.
interface symm_orth_iter_if #(
   parameter int N  = 4,
   parameter int DW = 26
);
   logic                  start_symm;
   logic                  mode_symm;
   logic [N*N*DW-1:0]     w_in;
   logic [N*N*DW-1:0]     w_out;
   logic                  busy_symm;
   logic                  done_symm;

   modport master (
      output start_symm, mode_symm, w_in,
      input  w_out, busy_symm, done_symm
   );

   modport slave (
      input  start_symm, mode_symm, w_in,
      output w_out, busy_symm, done_symm
   );
endinterface

// File: rtl/symm_orth_iter.sv
// One symmetric-orthogonalisation step: Q = (W*W^T)*W on a single time-shared MAC,
// returning 0.5*Q or 1.5*W - 0.5*Q saturated to DW bits.
module symm_orth_iter #(
   parameter int N    = 4,
   parameter int DW   = 26,
   parameter int FRAC = 13
) (
   input  logic            clk_symm,
   input  logic            rst_symm,
   symm_orth_iter_if.slave bus
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = 2*DW - FRAC + $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N-1);

   typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_t;

   function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
      if (v[AW-1:DW-1] == {(AW-DW+1){v[AW-1]}}) begin
         sat_dw = v[DW-1:0];
      end else if (v[AW-1]) begin
         sat_dw = {1'b1, {(DW-1){1'b0}}};
      end else begin
         sat_dw = {1'b0, {(DW-1){1'b1}}};
      end
   endfunction

   state_t                 state_q;
   logic                   mode_q, busy_q, done_q, fin_q;
   logic [CW-1:0]          r_q, c_q, k_q;
   logic [CW-1:0]          r_d, c_d, k_d;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic [N*N*DW-1:0]      w_out_q;
   logic signed [DW-1:0]   w_buf_q [N][N];
   logic signed [DW-1:0]   p_buf_q [N][N];
   logic signed [DW-1:0]   r_buf_q [N][N];

   logic signed [DW-1:0]   op_a_s, op_b_s;
   logic signed [2*DW-1:0] prod_s;
   logic signed [AW-1:0]   w_ext_s, upd_s;
   logic                   last_k_s, last_elem_s;

   assign bus.w_out     = w_out_q;
   assign bus.busy_symm = busy_q;
   assign bus.done_symm = done_q;

   // MAC operand selection, accumulation and counter stepping (k fastest, then c, then r)
   always_comb begin
      if (state_q == PH_A) begin
         op_a_s = w_buf_q[r_q][k_q];
         op_b_s = w_buf_q[c_q][k_q];
      end else begin
         op_a_s = p_buf_q[r_q][k_q];
         op_b_s = w_buf_q[k_q][c_q];
      end
      prod_s  = op_a_s * op_b_s;
      acc_d   = acc_q + AW'(prod_s >>> FRAC);
      w_ext_s = AW'(w_buf_q[r_q][c_q]);
      upd_s   = w_ext_s + (w_ext_s >>> 1'b1) - (acc_d >>> 1'b1);

      last_k_s    = (k_q == LAST);
      last_elem_s = last_k_s && (c_q == LAST) && (r_q == LAST);
      k_d = r_q;
      c_d = c_q;
      r_d = r_q;
      if (last_k_s) begin
         k_d = '0;
         if (c_q == LAST) begin
            c_d = '0;
            r_d = (r_q == LAST) ? '0 : r_q + 1'b1;
         end else begin
            c_d = c_q + 1'b1;
         end
      end else begin
         k_d = k_q + 1'b1;
      end
   end

   // Sequencer: PH_A fills P, PH_B fills the result buffer, one extra cycle publishes it
   always_ff @(posedge clk_symm) begin
      if (rst_symm) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fin_q   <= 1'b0;
         r_q     <= '0;
         c_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         w_out_q <= '0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               w_buf_q[i][j] <= '0;
               p_buf_q[i][j] <= '0;
               r_buf_q[i][j] <= '0;
            end
         end
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start_symm) begin
                  for (int i = 0; i < N; i++) begin
                     for (int j = 0; j < N; j++) begin
                        w_buf_q[i][j] <= bus.w_in[(i*N+j)*DW +: DW];
                     end
                  end
                  mode_q  <= bus.mode_symm;
                  r_q     <= '0;
                  c_q     <= '0;
                  k_q     <= '0;
                  acc_q   <= '0;
                  fin_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= PH_A;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            PH_A: begin
               acc_q <= last_k_s ? '0 : acc_d;
               if (last_k_s) begin
                  p_buf_q[r_q][c_q] <= sat_dw(acc_d);
               end
               r_q <= r_d;
               c_q <= c_d;
               k_q <= k_d;
               if (last_elem_s) begin
                  state_q <= PH_B;
               end
            end
            PH_B: begin
               if (fin_q) begin
                  for (int i = 0; i < N; i++) begin
                     for (int j = 0; j < N; j++) begin
                        w_out_q[(i*N+j)*DW +: DW] <= r_buf_q[i][j];
                     end
                  end
                  fin_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  acc_q <= last_k_s ? '0 : acc_d;
                  // the mode-1 update uses the unsaturated Q held in acc_d
                  if (last_k_s) begin
                     r_buf_q[r_q][c_q] <= mode_q ? sat_dw(upd_s) : sat_dw(acc_d >>> 1'b1);
                  end
                  r_q <= r_d;
                  c_q <= c_d;
                  k_q <= k_d;
                  if (last_elem_s) begin
                     fin_q <= 1'b1;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_symm_orth_iter.sv
// Randomised and directed bench for symm_orth_iter: stimulus pushes reference results into a
// scoreboard queue, a monitor pops and compares them whenever done_symm is seen.
module tb_symm_orth_iter;
   localparam int N    = 4;
   localparam int DW   = 26;
   localparam int FRAC = 13;
   localparam int NN   = N*N;
   localparam int LAT  = 2*N*N*N + 1;

   typedef struct {
      logic [NN*DW-1:0] exp;
      int               due;
   } item_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;
   int   busy_run = 0;
   item_t sb [$];
   logic [NN*DW-1:0] last_exp = '0;

   symm_orth_iter_if #(.N(N), .DW(DW)) bus ();

   symm_orth_iter #(.N(N), .DW(DW), .FRAC(FRAC)) dut (
      .clk_symm (clk),
      .rst_symm (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint satl(input longint v);
      longint mx = (64'sd1 <<< (DW-1)) - 64'sd1;
      longint mn = -(64'sd1 <<< (DW-1));
      if (v > mx) return mx;
      else if (v < mn) return mn;
      else return v;
   endfunction

   // Plain-arithmetic reference: P = sat(W*W^T), Q = P*W, each product truncated toward -inf
   function automatic logic [NN*DW-1:0] ref_model(input logic [NN*DW-1:0] win, input logic m);
      longint w [N][N];
      longint p [N][N];
      longint s;
      logic signed [DW-1:0] e;
      logic [NN*DW-1:0] res = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            e = win[(r*N+c)*DW +: DW];
            w[r][c] = longint'(e);
         end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += (w[r][k] * w[c][k]) >>> FRAC;
            p[r][c] = satl(s);
         end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += (p[r][k] * w[k][c]) >>> FRAC;
            res[(r*N+c)*DW +: DW] = DW'(m ? satl(w[r][c] + (w[r][c] >>> 1) - (s >>> 1))
                                          : satl(s >>> 1));
         end
      return res;
   endfunction

   function automatic logic [NN*DW-1:0] diag(input longint d);
      logic [NN*DW-1:0] v = '0;
      for (int i = 0; i < N; i++) v[(i*N+i)*DW +: DW] = DW'(d);
      return v;
   endfunction

   function automatic logic [NN*DW-1:0] rand_w(input int mag);
      logic [NN*DW-1:0] v;
      int t;
      for (int i = 0; i < NN; i++) begin
         t = int'($urandom_range(2*mag-2, 0)) - (mag-1);
         v[i*DW +: DW] = DW'(t);
      end
      return v;
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_vec(input string nm, input logic [NN*DW-1:0] act, input logic [NN*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic [NN*DW-1:0] w, input logic m);
      item_t it;
      it.exp = ref_model(w, m);
      it.due = cyc + LAT;
      last_exp = it.exp;
      sb.push_back(it);
   endtask

   // One start pulse; w_in and mode are scrambled right after the accepting edge
   task automatic drive_start(input logic [NN*DW-1:0] w, input logic m);
      @(negedge clk);
      bus.start_symm = 1'b1;
      bus.w_in       = w;
      bus.mode_symm  = m;
      @(posedge clk);
      #1;
      push_exp(w, m);
      @(negedge clk);
      bus.start_symm = 1'b0;
      bus.w_in       = rand_w(16384);
      bus.mode_symm  = ~m;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 2*LAT) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("job_timeout_pending", sb.size(), 0);
      if (sb.size() != 0) sb.delete();
   endtask

   // Monitor: compares every done pulse against the head of the scoreboard
   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            busy_run = 0;
         end else if (bus.done_symm === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: done seen at cycle %0d, expected none", cyc);
            end else begin
               it = sb.pop_front();
               check_vec("w_out", bus.w_out, it.exp);
               check("done_latency", cyc, it.due);
               check("busy_cycles", busy_run, LAT);
               check("busy_at_done", bus.busy_symm, 0);
            end
            busy_run = 0;
         end else if (bus.busy_symm === 1'b1) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end
   end

   initial begin
      logic [NN*DW-1:0] wv [3];
      logic             mv [3];
      logic [NN*DW-1:0] hold_v;
      int               d0;

      rst = 1'b1;
      bus.start_symm = 1'b0;
      bus.mode_symm  = 1'b0;
      bus.w_in       = '0;
      repeat (3) @(posedge clk);
      #1;
      check_vec("reset_w_out", bus.w_out, '0);
      check("reset_busy", bus.busy_symm, 0);
      check("reset_done", bus.done_symm, 0);
      @(negedge clk);
      rst = 1'b0;

      // directed: identity, half identity, saturation, -1 LSB
      for (int m = 0; m < 2; m++) begin
         drive_start(diag(64'sd8192), m[0]);       wait_idle();
         drive_start(diag(64'sd4096), m[0]);       wait_idle();
         drive_start(diag(64'sd16777216), m[0]);   wait_idle();
         drive_start(diag(-64'sd1), m[0]);         wait_idle();
      end
      drive_start(diag(64'sd8192), 1'b0);
      wait_idle();
      check("identity_m0_diag", longint'($signed(bus.w_out[0 +: DW])), 4096);
      check("identity_m0_offdiag", longint'($signed(bus.w_out[DW +: DW])), 0);

      // start pulsed at cycle 10 of busy is ignored
      d0 = done_seen;
      drive_start(diag(64'sd4096), 1'b1);
      repeat (9) @(negedge clk);
      bus.start_symm = 1'b1;
      bus.w_in       = rand_w(16384);
      @(negedge clk);
      bus.start_symm = 1'b0;
      wait_idle();
      repeat (LAT + 10) @(negedge clk);
      check("ignored_start_done_count", done_seen - d0, 1);

      // start held high: a new job is accepted in every DONE cycle
      for (int j = 0; j < 3; j++) begin
         wv[j] = rand_w(16384);
         mv[j] = j[0];
      end
      @(negedge clk);
      bus.start_symm = 1'b1;
      bus.w_in       = wv[0];
      bus.mode_symm  = mv[0];
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         #1;
         push_exp(wv[j], mv[j]);
         @(negedge clk);
         if (j < 2) begin
            bus.w_in      = wv[j+1];
            bus.mode_symm = mv[j+1];
            repeat (LAT) @(posedge clk);
         end else begin
            bus.start_symm = 1'b0;
            bus.w_in       = rand_w(16384);
         end
      end
      wait_idle();

      // reset at cycle 90 of a job aborts it; start asserted with reset is dropped
      hold_v = last_exp;
      d0 = done_seen;
      drive_start(rand_w(16384), 1'b1);
      repeat (89) @(negedge clk);
      check_vec("w_out_holds_during_job", bus.w_out, hold_v);
      rst = 1'b1;
      bus.start_symm = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      check_vec("abort_w_out", bus.w_out, '0);
      check("abort_busy", bus.busy_symm, 0);
      check("abort_done", bus.done_symm, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.start_symm = 1'b0;
      repeat (LAT + 20) @(negedge clk);
      check("abort_no_done", done_seen - d0, 0);
      check("abort_idle_busy", bus.busy_symm, 0);
      drive_start(diag(64'sd8192), 1'b1);
      wait_idle();

      // random signed W, |w| < 2^14, both modes
      for (int i = 0; i < 200; i++) begin
         drive_start(rand_w(16384), 1'($urandom_range(1, 0)));
         wait_idle();
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
